// File: rtl/ff_pkg.sv
// Shared constants for the foodfight switch-input conditioner:
// channel order of the ff core inputs, default polarity/coin masks, debounce time.
package ff_pkg;

   localparam int unsigned FF_NCH = 12;

   // Channel indices, matching the ff core input order
   localparam int unsigned CH_TEST    = 0;
   localparam int unsigned CH_THROW1  = 1;
   localparam int unsigned CH_THROW2  = 2;
   localparam int unsigned CH_COIN1   = 3;
   localparam int unsigned CH_START1  = 4;
   localparam int unsigned CH_START2  = 5;
   localparam int unsigned CH_COIN2   = 6;
   localparam int unsigned CH_COINAUX = 7;
   localparam int unsigned CH_JS_U    = 8;
   localparam int unsigned CH_JS_L    = 9;
   localparam int unsigned CH_JS_R    = 10;
   localparam int unsigned CH_JS_D    = 11;

   // All board switches are active-low
   localparam logic [FF_NCH-1:0] FF_INVERT    = '1;
   // coin1, coin2, coinaux get a stretched pulse
   localparam logic [FF_NCH-1:0] FF_COIN_MASK = 12'h0C8;

   // 5 ms at 6 MHz with a per-clock tick
   localparam int unsigned DB_5MS_6MHZ = 30000;

   // Single-bit mask for a channel index
   function automatic logic [FF_NCH-1:0] ch_bit(input int unsigned ch);
      logic [FF_NCH-1:0] m;
      m = '0;
      m[ch] = 1'b1;
      return m;
   endfunction

endpackage

// File: rtl/ff_input_cond_if.sv
// Switch-input bundle between the board pins side and the ff core side.
interface ff_input_cond_if #(
   parameter int unsigned NCH = 12
);
   logic           i_tick;
   logic [NCH-1:0] i_raw;
   logic [NCH-1:0] o_level;
   logic [NCH-1:0] o_rise;
   logic [NCH-1:0] o_fall;
   logic [NCH-1:0] o_stretch;

   modport master (
      output i_tick, i_raw,
      input  o_level, o_rise, o_fall, o_stretch
   );

   modport slave (
      input  i_tick, i_raw,
      output o_level, o_rise, o_fall, o_stretch
   );
endinterface

// File: rtl/ff_debounce_ch.sv
// One switch channel: 2-flop synchroniser, tick-qualified debounce counter,
// polarity correction and registered level/press/release outputs.
module ff_debounce_ch #(
   parameter int unsigned DB_BITS  = 16,
   parameter int unsigned DB_COUNT = 30000,
   parameter logic        INV      = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic tick,
   input  logic raw,
   output logic level,
   output logic rise,
   output logic fall
);

   localparam logic [DB_BITS-1:0] CNT_LAST = DB_BITS'(DB_COUNT - 1);

   logic               s1;
   logic               s2;
   logic               stable;
   logic [DB_BITS-1:0] cnt;
   logic               level_d;

   // Synchroniser; resets to the released raw level so no edge follows reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1 <= INV;
         s2 <= INV;
      end else begin
         s1 <= raw;
         s2 <= s1;
      end
   end

   // Accept a new level only after DB_COUNT consecutive mismatching ticks
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stable <= INV;
         cnt    <= '0;
      end else if (s2 == stable) begin
         cnt <= '0;
      end else if (tick) begin
         if (cnt == CNT_LAST) begin
            stable <= s2;
            cnt    <= '0;
         end else begin
            cnt <= cnt + DB_BITS'(1);
         end
      end
   end

   assign level_d = stable ^ INV;

   // Registered level with edge pulses aligned to the level change
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         level <= 1'b0;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         level <= level_d;
         rise  <= level_d & ~level;
         fall  <= ~level_d & level;
      end
   end

endmodule

// File: rtl/ff_input_cond.sv
// N-channel switch-input conditioner for the ff core: per-channel debounce,
// polarity correction, press/release pulses and stretched coin pulses.
module ff_input_cond
   import ff_pkg::*;
#(
   parameter int unsigned    NCH       = FF_NCH,
   parameter int unsigned    DB_BITS   = 16,
   parameter int unsigned    DB_COUNT  = DB_5MS_6MHZ,
   parameter logic [NCH-1:0] INVERT    = '1,
   parameter logic [NCH-1:0] COIN_MASK = NCH'(FF_COIN_MASK),
   parameter logic [7:0]     PULSE_LEN = 8'd200
) (
   input  logic           clk_6mhz,
   input  logic           reset_n,
   ff_input_cond_if.slave bus
);

   logic [NCH-1:0] level;
   logic [NCH-1:0] rise;
   logic [NCH-1:0] fall;
   logic [NCH-1:0] stretch;

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      ff_debounce_ch #(
         .DB_BITS  (DB_BITS),
         .DB_COUNT (DB_COUNT),
         .INV      (INVERT[i])
      ) u_ch (
         .clk   (clk_6mhz),
         .rst_n (reset_n),
         .tick  (bus.i_tick),
         .raw   (bus.i_raw[i]),
         .level (level[i]),
         .rise  (rise[i]),
         .fall  (fall[i])
      );
   end

   for (genvar i = 0; i < NCH; i++) begin : g_st
      if (COIN_MASK[i]) begin : g_coin
         logic [7:0] scnt;

         // Load on every press (reload beats expiry), otherwise count down to idle
         always_ff @(posedge clk_6mhz or negedge reset_n) begin
            if (!reset_n) begin
               scnt <= '0;
            end else if (rise[i]) begin
               scnt <= PULSE_LEN;
            end else if (scnt != '0) begin
               scnt <= scnt - 8'd1;
            end
         end

         assign stretch[i] = (scnt != '0);
      end else begin : g_plain
         assign stretch[i] = 1'b0;
      end
   end

   assign bus.o_level   = level;
   assign bus.o_rise    = rise;
   assign bus.o_fall    = fall;
   assign bus.o_stretch = stretch;

endmodule

// File: tb/tb_ff_input_cond.sv
// Bench for ff_input_cond: DB_COUNT=4/PULSE_LEN=5 instance for most scenarios,
// plus a DB_COUNT=1 instance where a press-release-press can land inside a stretch.
module tb_ff_input_cond;

   logic clk;
   logic reset_n;
   logic sel;

   int unsigned n_tests;
   int unsigned n_fail;

   ff_input_cond_if #(.NCH(12)) bus0 ();
   ff_input_cond_if #(.NCH(12)) bus1 ();

   ff_input_cond #(
      .NCH       (12),
      .DB_BITS   (16),
      .DB_COUNT  (4),
      .INVERT    (12'hFFF),
      .COIN_MASK (12'h0C8),
      .PULSE_LEN (8'd5)
   ) u_dut0 (
      .clk_6mhz (clk),
      .reset_n  (reset_n),
      .bus      (bus0)
   );

   ff_input_cond #(
      .NCH       (12),
      .DB_BITS   (16),
      .DB_COUNT  (1),
      .INVERT    (12'hFFF),
      .COIN_MASK (12'h0C8),
      .PULSE_LEN (8'd5)
   ) u_dut1 (
      .clk_6mhz (clk),
      .reset_n  (reset_n),
      .bus      (bus1)
   );

   typedef struct packed {
      logic [11:0] raw;
      logic [11:0] lvl;
      logic [11:0] rs;
      logic [11:0] fl;
      logic [11:0] st;
   } row_t;

   typedef struct {
      logic [47:0] exp;
      string       tag;
   } exp_t;

   row_t tbl [0:42];
   exp_t sb [$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout want $finish");
      $fatal(1);
   end

   function automatic logic [47:0] out0();
      return {bus0.o_level, bus0.o_rise, bus0.o_fall, bus0.o_stretch};
   endfunction

   function automatic logic [47:0] out1();
      return {bus1.o_level, bus1.o_rise, bus1.o_fall, bus1.o_stretch};
   endfunction

   task automatic check(input string tag, input logic [47:0] act, input logic [47:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h ({level,rise,fall,stretch} or value)", tag, act, exp);
      end
   endtask

   // Drive one cycle of stimulus, queue its expectation, compare after the edge
   task automatic cyc(input logic [11:0] raw, input logic tick,
                      input logic [11:0] lvl, input logic [11:0] rs,
                      input logic [11:0] fl, input logic [11:0] st,
                      input string tag);
      exp_t e;
      exp_t g;
      if (sel) begin
         bus1.i_raw = raw;
         bus0.i_raw = '1;
      end else begin
         bus0.i_raw = raw;
         bus1.i_raw = '1;
      end
      bus0.i_tick = tick;
      bus1.i_tick = tick;
      e.exp = {lvl, rs, fl, st};
      e.tag = tag;
      sb.push_back(e);
      @(posedge clk);
      #1;
      g = sb.pop_front();
      check(g.tag, sel ? out1() : out0(), g.exp);
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cyc(12'hFFF, 1'b1, '0, '0, '0, '0, "idle");
   endtask

   task automatic put(input int k0, input int k1, input logic [11:0] raw,
                      input logic [11:0] lvl, input logic [11:0] rs,
                      input logic [11:0] fl, input logic [11:0] st);
      for (int k = k0; k <= k1; k++) tbl[k] = {raw, lvl, rs, fl, st};
   endtask

   initial begin
      n_tests     = 0;
      n_fail      = 0;
      sel         = 1'b0;
      reset_n     = 1'b0;
      bus0.i_raw  = '1;
      bus1.i_raw  = '1;
      bus0.i_tick = 1'b1;
      bus1.i_tick = 1'b1;

      // Channel 7 clean press/release, then every channel at once
      put( 0,  5, 12'hF7F, 12'h000, 12'h000, 12'h000, 12'h000);
      put( 6,  6, 12'hF7F, 12'h080, 12'h080, 12'h000, 12'h000);
      put( 7, 11, 12'hF7F, 12'h080, 12'h000, 12'h000, 12'h080);
      put(12, 13, 12'hF7F, 12'h080, 12'h000, 12'h000, 12'h000);
      put(14, 19, 12'hFFF, 12'h080, 12'h000, 12'h000, 12'h000);
      put(20, 20, 12'hFFF, 12'h000, 12'h000, 12'h080, 12'h000);
      put(21, 21, 12'hFFF, 12'h000, 12'h000, 12'h000, 12'h000);
      put(22, 27, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000);
      put(28, 28, 12'h000, 12'hFFF, 12'hFFF, 12'h000, 12'h000);
      put(29, 33, 12'h000, 12'hFFF, 12'h000, 12'h000, 12'h0C8);
      put(34, 34, 12'h000, 12'hFFF, 12'h000, 12'h000, 12'h000);
      put(35, 40, 12'hFFF, 12'hFFF, 12'h000, 12'h000, 12'h000);
      put(41, 41, 12'hFFF, 12'h000, 12'h000, 12'hFFF, 12'h000);
      put(42, 42, 12'hFFF, 12'h000, 12'h000, 12'h000, 12'h000);

      // Reset: outputs quiet during and after release
      repeat (3) @(posedge clk);
      #1;
      check("reset_dut0", out0(), '0);
      check("reset_dut1", out1(), '0);
      @(negedge clk);
      reset_n = 1'b1;
      for (int k = 0; k < 4; k++) cyc(12'hFFF, 1'b1, '0, '0, '0, '0, $sformatf("post_reset[%0d]", k));
      check("post_reset_dut1", out1(), '0);

      for (int k = 0; k <= 42; k++)
         cyc(tbl[k].raw, 1'b1, tbl[k].lvl, tbl[k].rs, tbl[k].fl, tbl[k].st, $sformatf("table[%0d]", k));
      idle(2);

      // Glitch of DB_COUNT-1 clocks on channel 5 is rejected
      for (int k = 0; k <= 8; k++) begin
         cyc((k <= 2) ? 12'hFDF : 12'hFFF, 1'b1, '0, '0, '0, '0, $sformatf("glitch[%0d]", k));
         if (k == 4) check("glitch_cnt_peak", 48'(u_dut0.g_ch[5].u_ch.cnt), 48'd3);
      end
      check("glitch_cnt_clear", 48'(u_dut0.g_ch[5].u_ch.cnt), 48'd0);

      // Exactly DB_COUNT clocks low is accepted
      for (int k = 0; k <= 11; k++)
         cyc((k <= 3) ? 12'hFDF : 12'hFFF, 1'b1,
             (k >= 6 && k <= 9) ? 12'h020 : 12'h000,
             (k == 6)  ? 12'h020 : 12'h000,
             (k == 10) ? 12'h020 : 12'h000,
             12'h000, $sformatf("db_edge[%0d]", k));
      idle(2);

      // Sparse tick on channel 0: qualifying ticks at edges 2,5,8,11
      for (int k = 0; k <= 22; k++)
         cyc((k <= 14) ? 12'hFFE : 12'hFFF,
             (k <= 14) ? logic'(k % 3 == 2) : 1'b1,
             (k >= 12 && k <= 20) ? 12'h001 : 12'h000,
             (k == 12) ? 12'h001 : 12'h000,
             (k == 21) ? 12'h001 : 12'h000,
             12'h000, $sformatf("sparse[%0d]", k));
      idle(2);

      // Retrigger on channel 6 (DB_COUNT=1): second press reloads as the first stretch expires
      sel = 1'b1;
      idle(2);
      for (int k = 0; k <= 19; k++)
         cyc((k <= 2 || (k >= 5 && k <= 14)) ? 12'hFBF : 12'hFFF, 1'b1,
             ((k >= 3 && k <= 5) || (k >= 8 && k <= 17)) ? 12'h040 : 12'h000,
             (k == 3 || k == 8)  ? 12'h040 : 12'h000,
             (k == 6 || k == 18) ? 12'h040 : 12'h000,
             (k >= 4 && k <= 13) ? 12'h040 : 12'h000,
             $sformatf("retrig[%0d]", k));
      sel = 1'b0;
      idle(2);

      // Reset at cnt=2 on channel 3 aborts the debounce
      for (int k = 0; k <= 3; k++) cyc(12'hFF7, 1'b1, '0, '0, '0, '0, $sformatf("mrst_a[%0d]", k));
      check("mrst_cnt_before", 48'(u_dut0.g_ch[3].u_ch.cnt), 48'd2);
      reset_n = 1'b0;
      #1;
      check("mrst_cnt_async", 48'(u_dut0.g_ch[3].u_ch.cnt), 48'd0);
      check("mrst_out_async_a", out0(), '0);
      @(negedge clk);
      reset_n = 1'b1;
      for (int k = 0; k <= 8; k++)
         cyc(12'hFF7, 1'b1,
             (k >= 6) ? 12'h008 : 12'h000,
             (k == 6) ? 12'h008 : 12'h000,
             12'h000,
             (k >= 7) ? 12'h008 : 12'h000,
             $sformatf("mrst_b[%0d]", k));

      // Reset during the stretch drops everything at once
      reset_n = 1'b0;
      #1;
      check("mrst_out_async_b", out0(), '0);
      @(negedge clk);
      reset_n = 1'b1;
      for (int k = 0; k <= 16; k++)
         cyc((k <= 7) ? 12'hFF7 : 12'hFFF, 1'b1,
             (k >= 6 && k <= 13) ? 12'h008 : 12'h000,
             (k == 6)  ? 12'h008 : 12'h000,
             (k == 14) ? 12'h008 : 12'h000,
             (k >= 7 && k <= 11) ? 12'h008 : 12'h000,
             $sformatf("mrst_c[%0d]", k));
      idle(2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
